la_rrarb6: RTL and testbench
============================

// Module: la_rrarb6
// PURPOSE
//  Round-robin arbiter and sequencer for a 6-input one-hot data mux.
//  Shares one downstream sink among six requesters and drives registered,
//  glitch-free one-hot selects straight into the mux select pins.
//  Supports burst hold (up to MAXBURST accepted beats per grant) and per-requester masking.
// PARAMETERS
//  PROP      "DEFAULT"  cell property, passed through to implementation cells
//  MAXBURST  4          max accepted beats per grant before forced rotation (>=1)
// PORTS
//  clk    in   1  clock; all state updates on rising edge
//  rst    in   1  synchronous active-high reset
//  req    in   6  request per requester, held high while it has data
//  mask   in   6  1 = requester disabled; excluded from arbitration
//  ready  in   1  sink accepts the mux output this cycle
//  sel    out  6  registered one-hot mux select (all-zero = idle); sel[i] -> mux sel<i>
//  owner  out  3  binary index of current owner (0..5); 0 when idle
//  valid  out  1  |(sel & req & ~mask): mux output carries live data
//  ack    out  6  sel & req & ~mask & {6{ready}}: per-requester beat accepted
// BEHAVIOUR
//  - Reset: sel=0, owner=0, cnt=0, ptr=5. With ptr=5, req0 has top priority after reset.
//  - elig = req & ~mask. valid and ack are combinational from registered sel. No req->ack comb path through arbitration.
//  - States: IDLE (sel==0) and GRANT (sel one-hot).
//  - Pick: first eligible index scanning ptr+1, ptr+2, ... mod 6. ptr = index of last owner.
//  - IDLE: if elig!=0, at next edge sel<=onehot(pick), owner<=pick, ptr<=pick, cnt<=0.
//    Req-to-sel latency is 1 cycle. If elig==0, stay idle.
//  - GRANT hold: keep sel while elig[owner]=1 and burst not exhausted.
//    - ready=0: hold, cnt unchanged.
//    - ack: cnt<=cnt+1.
//  - Release at edge when any of:
//    (a) elig[owner]==0, due to req drop or mask set; no ack counted that cycle;
//    (b) ack and cnt==MAXBURST-1.
//  - On release, re-arbitrate in the same edge; ptr=current owner, so the owner is lowest priority.
//    - Another eligible requester: grant it with no idle bubble, cnt<=0.
//    - Only the old owner eligible (case b): re-grant it, cnt<=0.
//    - None eligible: go IDLE.
//  - sel is never multi-hot. Changes only at clock edges and only via release or IDLE exit.
//  - cnt width = max(1,$clog2(MAXBURST)). MAXBURST=1 rotates after every ack.
//  - mask/req changes to non-owners never disturb the current grant.
//  - rst mid-burst: next edge gives the reset values above. In-flight beat with ready=0 is dropped.
//  - Simultaneous rst and ack: reset wins.
// STRUCTURE
//  - Shared package la_arb_pkg: localparams LA_ARB_N=6, LA_ARB_IW=3, and function onehot6(idx).
//  - Sub-module la_rrpick6 (combinational): inputs elig[5:0] and ptr[2:0]; outputs pick[2:0] and any.
//    Implemented as a rotate/priority/unrotate picker; reused for the IDLE and release paths.
//  - Top module: FSM, ptr/owner/cnt registers, and the sel register.
// TESTING
//  - Reset, then req=6'b111111, ready=1, MAXBURST=1
//    -> sel sequence 000001,000010,...,100000,000001; one ack per cycle; no idle cycles.
//  - req=6'b000100 held, ready=1, MAXBURST=4
//    -> sel=000100 from cycle 1; 4 acks; cnt wraps; re-granted with no bubble.
//  - Owner=2 mid-burst (cnt=1), ready toggles 0,1,0,1
//    -> sel steady; acks only when ready=1; cnt 1->2->3; release after the 4th beat.
//  - Owner=3, req=6'b101000; set mask[3]=1
//    -> next edge sel=100000 (req5), no ack counted for req3 that cycle.
//  - Owner=1; drop req=0 -> next edge sel=0, valid=0. Then req=6'b000011
//    -> sel=000010? no: ptr=1, so pick 0 -> sel=000001.
//  - Assert rst during owner=4, cnt=2 -> next edge sel=0, owner=0.
//    With req=6'b010001 after release, first grant is sel=000001.

Source files
------------

// File: rtl/la_arb_pkg.sv
// Shared constants and helpers for the six-way round-robin arbiter.
package la_arb_pkg;

    localparam int unsigned LA_ARB_N  = 6;
    localparam int unsigned LA_ARB_IW = 3;

    // Binary index to one-hot select; indices above 5 give all-zero.
    function automatic logic [LA_ARB_N-1:0] onehot6(input logic [LA_ARB_IW-1:0] idx);
        onehot6 = LA_ARB_N'(1) << idx;
    endfunction

endpackage

// File: rtl/la_rrpick6.sv
// Combinational round-robin picker: first eligible index after ptr, wrapping mod 6.
module la_rrpick6
    import la_arb_pkg::*;
#(
    parameter string PROP = "DEFAULT"
) (
    input  logic [LA_ARB_N-1:0]  elig,
    input  logic [LA_ARB_IW-1:0] ptr,
    output logic [LA_ARB_IW-1:0] pick,
    output logic                 any
);

    logic [LA_ARB_N-1:0] rot;
    int                  base;
    int                  off;

    // Rotate so ptr+1 lands at bit 0, take the lowest set bit, then unrotate.
    always_comb begin
        rot  = '0;
        base = int'(ptr) + 1;
        off  = 0;
        for (int i = 0; i < LA_ARB_N; i++) begin
            rot[i] = elig[(base + i) % LA_ARB_N];
        end
        for (int i = LA_ARB_N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
            end
        end
        any  = |elig;
        pick = LA_ARB_IW'((base + off) % LA_ARB_N);
    end

endmodule

// File: rtl/la_rrarb6.sv
// Round-robin arbiter driving registered one-hot selects for a 6-input mux,
// with burst hold up to MAXBURST accepted beats and per-requester masking.
module la_rrarb6
    import la_arb_pkg::*;
#(
    parameter string       PROP     = "DEFAULT",
    parameter int unsigned MAXBURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LA_ARB_N-1:0]  req,
    input  logic [LA_ARB_N-1:0]  mask,
    input  logic                 ready,
    output logic [LA_ARB_N-1:0]  sel,
    output logic [LA_ARB_IW-1:0] owner,
    output logic                 valid,
    output logic [LA_ARB_N-1:0]  ack
);

    localparam int unsigned    CW       = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(MAXBURST - 1);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e                state_q, state_d;
    logic [LA_ARB_N-1:0]   sel_q, sel_d;
    logic [LA_ARB_IW-1:0]  owner_q, owner_d;
    logic [LA_ARB_IW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [LA_ARB_N-1:0]   elig;
    logic [LA_ARB_IW-1:0]  pick;
    logic                  any;
    logic                  owner_elig;
    logic                  rearb;

    assign elig = req & ~mask;

    // ptr holds the last owner, so on release the old owner drops to lowest priority.
    la_rrpick6 #(
        .PROP (PROP)
    ) u_pick (
        .elig (elig),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    // Next-state: idle exit, burst hold/count, release with same-edge re-arbitration.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        rearb      = 1'b0;
        owner_elig = elig[owner_q];
        unique case (state_q)
            StIdle: begin
                rearb = 1'b1;
            end
            StGrant: begin
                if (!owner_elig) begin
                    rearb = 1'b1;
                end else if (ready) begin
                    if (cnt_q == CNT_LAST) begin
                        rearb = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: ;
        endcase
        if (rearb) begin
            if (any) begin
                state_d = StGrant;
                sel_d   = onehot6(pick);
                owner_d = pick;
                ptr_d   = pick;
                cnt_d   = '0;
            end else begin
                state_d = StIdle;
                sel_d   = '0;
                owner_d = '0;
                cnt_d   = '0;
            end
        end
    end

    // State registers; reset overrides any beat accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
            owner_q <= '0;
            ptr_q   <= LA_ARB_IW'(LA_ARB_N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel   = sel_q;
    assign owner = owner_q;
    assign valid = |(sel_q & elig);
    assign ack   = sel_q & elig & {LA_ARB_N{ready}};

endmodule

// File: tb/tb_la_rrarb6.sv
// Self-checking bench: two arbiters (MAXBURST=1 and 4) share stimulus; a
// reference model pushes expected sel/owner per edge into scoreboard queues.
module tb_la_rrarb6;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [5:0] req;
    logic [5:0] mask;

    logic [5:0] sel1, ack1, sel4, ack4;
    logic [2:0] own1, own4;
    logic       val1, val4;

    always #5 clk = ~clk;

    la_rrarb6 #(.MAXBURST(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .mask  (mask),
        .ready (ready),
        .sel   (sel1),
        .owner (own1),
        .valid (val1),
        .ack   (ack1)
    );

    la_rrarb6 #(.MAXBURST(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .mask  (mask),
        .ready (ready),
        .sel   (sel4),
        .owner (own4),
        .valid (val4),
        .ack   (ack4)
    );

    typedef struct packed {
        logic [5:0] sel;
        logic [2:0] owner;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 -> MAXBURST=1, index 1 -> MAXBURST=4.
    logic [5:0] m_sel[2];
    logic [2:0] m_own[2];
    logic [2:0] m_ptr[2];
    int         m_cnt[2];
    int         mb[2] = '{1, 4};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_rr(input logic [5:0] e, input logic [2:0] p);
        for (int j = 1; j <= 6; j++) begin
            int idx;
            idx = (int'(p) + j) % 6;
            if (e[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_edge(input int k);
        logic [5:0] e;
        int         p;
        bit         rel;
        e   = req & ~mask;
        rel = 1'b0;
        if (rst) begin
            m_sel[k] = '0;
            m_own[k] = '0;
            m_ptr[k] = 3'd5;
            m_cnt[k] = 0;
        end else begin
            if (m_sel[k] == '0) begin
                rel = 1'b1;
            end else if (!e[m_own[k]]) begin
                rel = 1'b1;
            end else if (ready) begin
                if (m_cnt[k] == mb[k] - 1) rel = 1'b1;
                else m_cnt[k] = m_cnt[k] + 1;
            end
            if (rel) begin
                p = pick_rr(e, m_ptr[k]);
                if (p >= 0) begin
                    m_sel[k] = 6'd1 << p;
                    m_own[k] = 3'(p);
                    m_ptr[k] = 3'(p);
                    m_cnt[k] = 0;
                end else begin
                    m_sel[k] = '0;
                    m_own[k] = '0;
                    m_cnt[k] = 0;
                end
            end
        end
    endtask

    // One clock: drive, check comb outputs, push expectation, compare after edge.
    task automatic step(input logic [5:0] r, input logic [5:0] m, input logic rd, input logic rs);
        logic [5:0] e;
        exp_t       x;
        @(negedge clk);
        req   = r;
        mask  = m;
        ready = rd;
        rst   = rs;
        #1;
        e = r & ~m;
        check("valid1", val1, |(m_sel[0] & e));
        check("ack1", ack1, m_sel[0] & e & {6{rd}});
        check("valid4", val4, |(m_sel[1] & e));
        check("ack4", ack4, m_sel[1] & e & {6{rd}});
        model_edge(0);
        model_edge(1);
        q1.push_back('{sel: m_sel[0], owner: m_own[0]});
        q4.push_back('{sel: m_sel[1], owner: m_own[1]});
        @(posedge clk);
        #1;
        x = q1.pop_front();
        check("sel1", sel1, x.sel);
        check("owner1", own1, x.owner);
        x = q4.pop_front();
        check("sel4", sel4, x.sel);
        check("owner4", own4, x.owner);
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        mask  = '0;
        ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = '0;
            m_own[k] = '0;
            m_ptr[k] = 3'd5;
            m_cnt[k] = 0;
        end

        // Reset state
        step(6'h00, 6'h00, 1'b1, 1'b1);
        step(6'h00, 6'h00, 1'b1, 1'b1);
        check("rst_sel", sel4, 6'b000000);
        check("rst_owner", own4, 3'd0);

        // All requesting, MAXBURST=1 rotates every beat starting at req0
        for (int k = 0; k < 8; k++) begin
            step(6'h3f, 6'h00, 1'b1, 1'b0);
            check("mb1_seq", sel1, 6'd1 << (k % 6));
        end

        // Single requester held: continuous grant, re-granted after 4 beats
        step(6'h00, 6'h00, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(6'b000100, 6'h00, 1'b1, 1'b0);
            check("hold2", sel4, 6'b000100);
        end

        // Owner 2 mid-burst with ready toggling
        step(6'h00, 6'h00, 1'b1, 1'b1);
        step(6'b000100, 6'h00, 1'b1, 1'b0);
        step(6'b000100, 6'h00, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(6'b100100, 6'h00, 1'(k % 2), 1'b0);
        end

        // Owner 3, mask it off: next owner is req5
        step(6'h00, 6'h00, 1'b1, 1'b1);
        step(6'b001000, 6'h00, 1'b0, 1'b0);
        step(6'b101000, 6'h00, 1'b0, 1'b0);
        step(6'b101000, 6'b001000, 1'b1, 1'b0);
        check("mask3", sel4, 6'b100000);

        // Owner 1 drops request, then 0 and 1 request: ptr=1 favours 0
        step(6'h00, 6'h00, 1'b1, 1'b1);
        step(6'b000010, 6'h00, 1'b0, 1'b0);
        step(6'b000000, 6'h00, 1'b0, 1'b0);
        check("drop_sel", sel4, 6'b000000);
        check("drop_valid", val4, 1'b0);
        step(6'b000011, 6'h00, 1'b0, 1'b0);
        check("after_drop", sel4, 6'b000001);

        // Reset mid-burst (owner 4, cnt 2) with ready high
        step(6'h00, 6'h00, 1'b1, 1'b1);
        step(6'b010000, 6'h00, 1'b1, 1'b0);
        step(6'b010000, 6'h00, 1'b1, 1'b0);
        step(6'b010000, 6'h00, 1'b1, 1'b0);
        step(6'b010000, 6'h00, 1'b1, 1'b1);
        check("rst_mid_sel", sel4, 6'b000000);
        check("rst_mid_own", own4, 3'd0);
        step(6'b010001, 6'h00, 1'b1, 1'b0);
        check("post_rst", sel4, 6'b000001);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(6'($urandom), 6'($urandom & $urandom), 1'($urandom), ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
